pe_broadcast_scheduler: RTL and testbench

- Root-side controller that sequences the activation broadcast phase of a layer across all PEs.
- Launches PEs one at a time, so only one PE injects activations into the router network at any moment.
- Waits for each PE's completion packet before launching the next PE.
- Signals layer completion, and flags protocol errors and timeouts.

---
 rtl/pe_broadcast_scheduler.sv | 164 ++++++++++++++++
 tb/tb_pe_broadcast_scheduler.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_broadcast_scheduler.sv
// Root-side scheduler for the activation broadcast phase: launches enabled PEs one at a
// time, waits for each completion packet, and reports layer completion, protocol errors and timeouts.
module pe_broadcast_scheduler #(
    parameter int NUM_PE            = 16,
    parameter int PE_IDX_WIDTH      = 4,
    parameter int DATA_WIDTH        = 16,
    parameter int ROUTER_ADDR_WIDTH = 16,
    parameter int TIMEOUT           = 4096,
    parameter int TO_CNT_WIDTH      = 13
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         layer_start,
    input  logic [NUM_PE-1:0]            pe_enable_mask,
    output logic [NUM_PE-1:0]            pe_start_calc,
    input  logic                         cpl_valid,
    output logic                         cpl_rdy,
    input  logic [ROUTER_ADDR_WIDTH-1:0] cpl_addr,
    input  logic [DATA_WIDTH-1:0]        cpl_data,
    output logic                         busy,
    output logic [PE_IDX_WIDTH-1:0]      cur_pe,
    output logic                         layer_done,
    output logic                         err_proto,
    output logic                         err_timeout
);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_CPL,
        DONE
    } state_t;

    localparam logic [TO_CNT_WIDTH-1:0] TO_LAST =
        TO_CNT_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t                    state_q, state_d;
    logic [NUM_PE-1:0]         pending_q, pending_d;
    logic [PE_IDX_WIDTH-1:0]   cur_pe_q, cur_pe_d;
    logic [TO_CNT_WIDTH-1:0]   to_cnt_q, to_cnt_d;
    logic                      err_proto_q, err_proto_d;
    logic                      err_timeout_q, err_timeout_d;

    logic [NUM_PE-1:0]         pending_clr;
    logic                      cpl_match;
    logic                      timeout_hit;
    logic                      unused_cpl_bits;

    // Only the address MSB and the index field of the data carry meaning here.
    assign unused_cpl_bits = ^{cpl_addr[ROUTER_ADDR_WIDTH-2:0],
                               cpl_data[DATA_WIDTH-1:PE_IDX_WIDTH]};

    // Lowest set bit of mask at or above index 'first'; callers guarantee one exists.
    function automatic logic [PE_IDX_WIDTH-1:0] find_lowest(
        input logic [NUM_PE-1:0] mask,
        input int unsigned       first
    );
        logic                    found;
        logic [PE_IDX_WIDTH-1:0] idx;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_PE; i++) begin
            if (!found && i >= first && mask[i]) begin
                found = 1'b1;
                idx   = PE_IDX_WIDTH'(i);
            end
        end
        return idx;
    endfunction

    assign pending_clr = pending_q & ~(NUM_PE'(1) << cur_pe_q);
    assign cpl_match   = (state_q == WAIT_CPL) && cpl_valid
                         && cpl_addr[ROUTER_ADDR_WIDTH-1]
                         && (cpl_data[PE_IDX_WIDTH-1:0] == cur_pe_q);
    assign timeout_hit = (TIMEOUT > 0) && (state_q == WAIT_CPL)
                         && !cpl_match && (to_cnt_q == TO_LAST);

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        cur_pe_d      = cur_pe_q;
        to_cnt_d      = to_cnt_q;
        err_proto_d   = err_proto_q;
        err_timeout_d = err_timeout_q;
        case (state_q)
            IDLE: begin
                if (layer_start) begin
                    pending_d     = pe_enable_mask;
                    err_proto_d   = 1'b0;
                    err_timeout_d = 1'b0;
                    if (|pe_enable_mask) begin
                        cur_pe_d = find_lowest(pe_enable_mask, 0);
                        state_d  = LAUNCH;
                    end else begin
                        cur_pe_d = '0;
                        state_d  = DONE;
                    end
                end
            end
            LAUNCH: begin
                to_cnt_d = '0;
                state_d  = WAIT_CPL;
            end
            WAIT_CPL: begin
                if (cpl_valid && !cpl_match) begin
                    err_proto_d = 1'b1;
                end
                if (timeout_hit) begin
                    err_timeout_d = 1'b1;
                end
                if (cpl_match || timeout_hit) begin
                    pending_d = pending_clr;
                    if (pending_clr == '0) begin
                        state_d = DONE;
                    end else begin
                        cur_pe_d = find_lowest(pending_clr, 32'(cur_pe_q) + 1);
                        state_d  = LAUNCH;
                    end
                end else if (TIMEOUT > 0) begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            pending_q     <= '0;
            cur_pe_q      <= '0;
            to_cnt_q      <= '0;
            err_proto_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            cur_pe_q      <= cur_pe_d;
            to_cnt_q      <= to_cnt_d;
            err_proto_q   <= err_proto_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    always_comb begin
        pe_start_calc = '0;
        for (int unsigned i = 0; i < NUM_PE; i++) begin
            pe_start_calc[i] = (state_q == LAUNCH) && (cur_pe_q == PE_IDX_WIDTH'(i));
        end
    end

    assign cpl_rdy     = (state_q == WAIT_CPL);
    assign busy        = (state_q == LAUNCH) || (state_q == WAIT_CPL);
    assign layer_done  = (state_q == DONE);
    assign cur_pe      = cur_pe_q;
    assign err_proto   = err_proto_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_pe_broadcast_scheduler.sv
// Self-checking bench for pe_broadcast_scheduler: table-driven layer runs with a launch-order
// scoreboard, plus hand-written protocol-error, timeout and mid-layer reset sequences.
module tb_pe_broadcast_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        layer_start;
    logic [15:0] pe_enable_mask;
    logic [15:0] pe_start_calc;
    logic        cpl_valid;
    logic        cpl_rdy;
    logic [15:0] cpl_addr;
    logic [15:0] cpl_data;
    logic        busy;
    logic [3:0]  cur_pe;
    logic        layer_done;
    logic        err_proto;
    logic        err_timeout;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    pe_broadcast_scheduler #(
        .NUM_PE(16),
        .PE_IDX_WIDTH(4),
        .DATA_WIDTH(16),
        .ROUTER_ADDR_WIDTH(16),
        .TIMEOUT(8),
        .TO_CNT_WIDTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .layer_start(layer_start),
        .pe_enable_mask(pe_enable_mask),
        .pe_start_calc(pe_start_calc),
        .cpl_valid(cpl_valid),
        .cpl_rdy(cpl_rdy),
        .cpl_addr(cpl_addr),
        .cpl_data(cpl_data),
        .busy(busy),
        .cur_pe(cur_pe),
        .layer_done(layer_done),
        .err_proto(err_proto),
        .err_timeout(err_timeout)
    );

    // delay: WAIT_CPL cycles the responder lets pass before presenting a matching packet
    // restart_cycle: cycle of an extra layer_start pulse while busy (0 = none)
    typedef struct {
        logic [15:0] mask;
        int unsigned delay;
        int unsigned restart_cycle;
        int unsigned exp_done;
        logic        exp_to;
    } vec_t;

    vec_t        vecs[7];
    int unsigned exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cpl_valid = 1'b0;
    endtask

    task automatic drive_cpl(input logic [15:0] addr, input logic [15:0] data);
        cpl_valid = 1'b1;
        cpl_addr  = addr;
        cpl_data  = data;
    endtask

    // Leaves the bench at cycle 1 (just after the edge that samples layer_start).
    task automatic start_layer(input logic [15:0] m);
        @(negedge clk);
        layer_start    = 1'b1;
        pe_enable_mask = m;
        @(posedge clk);
        #1;
        layer_start = 1'b0;
    endtask

    function automatic logic [24:0] all_outs();
        return {pe_start_calc, cpl_rdy, busy, cur_pe, layer_done, err_proto, err_timeout};
    endfunction

    task automatic run_vec(input int unsigned id, input vec_t v);
        int unsigned c;
        int unsigned w;
        int unsigned cur;
        logic        done_seen;
        logic        busy_ok;
        exp_q.delete();
        for (int unsigned i = 0; i < 16; i++) begin
            if (v.mask[i]) exp_q.push_back(i);
        end
        done_seen = 1'b0;
        busy_ok   = 1'b1;
        w         = 0;
        cur       = 0;
        start_layer(v.mask);
        pe_enable_mask = 16'($urandom);
        c = 1;
        while (1) begin
            cpl_valid   = 1'b0;
            layer_start = 1'b0;
            if (v.restart_cycle == c) begin
                layer_start    = 1'b1;
                pe_enable_mask = ~v.mask;
            end
            if (busy !== ((v.mask != 16'h0) && (c < v.exp_done))) busy_ok = 1'b0;
            if (pe_start_calc != 16'h0) begin
                if (exp_q.size() == 0) begin
                    chk($sformatf("v%0d unexpected launch", id), {48'h0, pe_start_calc}, 64'h0);
                end else begin
                    logic [15:0] oh;
                    cur = exp_q.pop_front();
                    oh  = 16'h1 << cur;
                    chk($sformatf("v%0d launch c%0d", id, c), {48'h0, pe_start_calc}, {48'h0, oh});
                end
                w = 0;
            end else if (cpl_rdy) begin
                if (w == v.delay) drive_cpl(16'h8000, 16'(cur));
                w++;
            end
            if (layer_done) begin
                done_seen = 1'b1;
                chk($sformatf("v%0d done cycle", id), 64'(c), 64'(v.exp_done));
                chk($sformatf("v%0d err_timeout", id), {63'h0, err_timeout}, {63'h0, v.exp_to});
                chk($sformatf("v%0d err_proto", id), {63'h0, err_proto}, 64'h0);
                chk($sformatf("v%0d launches left", id), 64'(exp_q.size()), 64'h0);
            end
            if (done_seen || c >= 200) break;
            @(posedge clk);
            #1;
            c++;
        end
        if (!done_seen) chk($sformatf("v%0d layer_done timeout", id), 64'h0, 64'h1);
        chk($sformatf("v%0d busy profile", id), {63'h0, busy_ok}, 64'h1);
        layer_start = 1'b0;
        tick();
    endtask

    initial begin
        vecs[0] = '{16'h0005, 0, 0,  5, 1'b0};
        vecs[1] = '{16'h0000, 0, 0,  1, 1'b0};
        vecs[2] = '{16'hFFFF, 0, 0, 33, 1'b0};
        vecs[3] = '{16'h8001, 7, 0, 19, 1'b0};  // match lands in the last watchdog cycle
        vecs[4] = '{16'h0003, 8, 0, 19, 1'b1};  // neither PE answers in time
        vecs[5] = '{16'h0010, 3, 2,  6, 1'b0};
        vecs[6] = '{16'h0003, 0, 3,  5, 1'b0};

        rst            = 1'b0;
        layer_start    = 1'b0;
        pe_enable_mask = '0;
        cpl_valid      = 1'b0;
        cpl_addr       = '0;
        cpl_data       = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", 64'(all_outs()), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("post-reset outputs", 64'(all_outs()), 64'h0);

        for (int unsigned i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Protocol errors while awaiting PE 3
        start_layer(16'h0008);
        chk("proto launch", {48'h0, pe_start_calc}, 64'h0008);
        chk("proto cur_pe", 64'(cur_pe), 64'd3);
        tick();
        chk("proto rdy", {63'h0, cpl_rdy}, 64'h1);
        drive_cpl(16'h8000, 16'd5);
        tick();
        chk("proto err after bad index", {63'h0, err_proto}, 64'h1);
        chk("proto still waiting", {59'h0, cpl_rdy, cur_pe}, {59'h0, 1'b1, 4'd3});
        drive_cpl(16'h0000, 16'd3);
        tick();
        chk("proto still waiting after msb0", {47'h0, cpl_rdy, pe_start_calc}, {47'h0, 1'b1, 16'h0});
        drive_cpl(16'h8000, 16'd3);
        tick();
        chk("proto done", {62'h0, layer_done, err_proto}, 64'h3);
        tick();
        start_layer(16'h0001);
        chk("proto cleared by start", {63'h0, err_proto}, 64'h0);
        tick();
        drive_cpl(16'h8000, 16'd0);
        tick();
        chk("proto second layer done", {63'h0, layer_done}, 64'h1);
        tick();

        // PE 0 silent, PE 1 answers
        start_layer(16'h0003);
        chk("to launch pe0", {48'h0, pe_start_calc}, 64'h0001);
        repeat (8) tick();
        chk("to not yet", {62'h0, err_timeout, cpl_rdy}, 64'h1);
        tick();
        chk("to flagged", {63'h0, err_timeout}, 64'h1);
        chk("to launch pe1", {48'h0, pe_start_calc}, 64'h0002);
        tick();
        drive_cpl(16'h8000, 16'd1);
        tick();
        chk("to done sticky", {62'h0, layer_done, err_timeout}, 64'h3);
        tick();

        // Reset in the middle of a layer
        start_layer(16'hFFFF);
        tick();
        drive_cpl(16'h8000, 16'd0);
        tick();
        tick();
        drive_cpl(16'h8000, 16'd9);
        tick();
        chk("pre-reset state", {58'h0, err_proto, cpl_rdy, cur_pe}, {58'h0, 1'b1, 1'b1, 4'd1});
        #2;
        rst = 1'b0;
        #1;
        chk("async reset outputs", 64'(all_outs()), 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int unsigned i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("idle after reset %0d", i), {47'h0, busy, pe_start_calc}, 64'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global time limit: got no finish expected finish");
        $fatal(1);
    end

endmodule
